// File: rtl/alu_seq_muldiv_if.sv
// Handshaked operand/result bundle for alu_seq_muldiv.
// The producer side (decode/regfile) uses master; the ALU uses slave.
interface alu_seq_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Result;
  logic            V;
  logic            C;
  logic            Z;
  logic            N;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Result, V, C, Z, N
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Result, V, C, Z, N
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Integer ALU with single-cycle basic ops and iterative unsigned MUL/MULHU/DIVU/REMU.
// Result and V/C/Z/N are registered and held in DONE until the consumer takes them.
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_muldiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE   = SHW'(1);

  logic [1:0]        state;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd_b;
  logic [3:0]        op_r;
  logic [XLEN-1:0]   result_r;
  logic              v_r, c_r, z_r, n_r;

  logic              is_iter;
  logic [SHW-1:0]    shamt;
  logic [XLEN:0]     add_w, sub_w;
  logic              lt_s, lt_u;
  logic [XLEN-1:0]   basic_res;
  logic              basic_v, basic_c;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_r, div_t;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   iter_res;

  assign is_iter = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
  assign shamt   = bus.B[SHW-1:0];
  assign add_w   = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_w   = {1'b0, bus.A} + {1'b0, ~bus.B} + {{XLEN{1'b0}}, 1'b1};
  assign lt_s    = $signed(bus.A) < $signed(bus.B);
  assign lt_u    = bus.A < bus.B;

  always_comb begin
    basic_res = '0;
    basic_v   = 1'b0;
    basic_c   = 1'b0;
    case (bus.op)
      4'd0: begin
        basic_res = add_w[XLEN-1:0];
        basic_c   = add_w[XLEN];
        basic_v   = (bus.A[XLEN-1] == bus.B[XLEN-1]) && (add_w[XLEN-1] != bus.A[XLEN-1]);
      end
      4'd1: begin
        basic_res = sub_w[XLEN-1:0];
        basic_c   = sub_w[XLEN];
        basic_v   = (bus.A[XLEN-1] != bus.B[XLEN-1]) && (sub_w[XLEN-1] != bus.A[XLEN-1]);
      end
      4'd2:    basic_res = bus.A & bus.B;
      4'd3:    basic_res = bus.A | bus.B;
      4'd4:    basic_res = bus.A ^ bus.B;
      4'd5:    basic_res = {{(XLEN-1){1'b0}}, lt_s};
      4'd6:    basic_res = {{(XLEN-1){1'b0}}, lt_u};
      4'd7:    basic_res = bus.A << shamt;
      4'd8:    basic_res = bus.A >> shamt;
      4'd9:    basic_res = $unsigned($signed(bus.A) >>> shamt);
      default: basic_res = '0;
    endcase
  end

  // acc holds {high, low}: multiply shifts the partial product right, while
  // divide shifts {remainder, dividend/quotient} left one bit per step.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : {(XLEN+1){1'b0}});
  assign div_r   = acc[2*XLEN-1:XLEN-1];
  assign div_t   = div_r - {1'b0, opnd_b};

  always_comb begin
    if (op_r == OP_MUL || op_r == OP_MULHU)
      acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (div_t[XLEN])
      acc_next = {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_next = {div_t[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    iter_res = (op_r == OP_MUL || op_r == OP_DIVU) ? acc_next[XLEN-1:0]
                                                   : acc_next[2*XLEN-1:XLEN];
  end

  // A zero divisor never borrows, so DIVU yields all ones and REMU yields A.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      op_r     <= '0;
      result_r <= '0;
      v_r      <= 1'b0;
      c_r      <= 1'b0;
      z_r      <= 1'b0;
      n_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_r <= bus.op;
            if (is_iter) begin
              acc    <= {{XLEN{1'b0}}, bus.A};
              opnd_b <= bus.B;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              result_r <= basic_res;
              v_r      <= basic_v;
              c_r      <= basic_c;
              z_r      <= (basic_res == '0);
              n_r      <= basic_res[XLEN-1];
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_ITER) begin
            result_r <= iter_res;
            v_r      <= 1'b0;
            c_r      <= 1'b0;
            z_r      <= (iter_res == '0);
            n_r      <= iter_res[XLEN-1];
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Result    = result_r;
  assign bus.V         = v_r;
  assign bus.C         = c_r;
  assign bus.Z         = z_r;
  assign bus.N         = n_r;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: a 32-bit and an 8-bit instance share clk/rst,
// expected results come from a wide-arithmetic reference model.
module tb_alu_seq_muldiv;
  logic clk;
  logic rst;

  alu_seq_muldiv_if #(.XLEN(32)) if32 ();
  alu_seq_muldiv_if #(.XLEN(8))  if8 ();

  alu_seq_muldiv #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  alu_seq_muldiv #(.XLEN(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: 64-bit arithmetic masked to width w; flags packed {V,C,Z,N}.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] a_in, input logic [31:0] b_in);
    longint unsigned mask, a, b, s;
    longint sa, sb;
    int sh;
    logic v, c;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    a  = {32'd0, a_in} & mask;
    b  = {32'd0, b_in} & mask;
    sa = a[w-1] ? longint'(a) - longint'(mask) - 1 : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(mask) - 1 : longint'(b);
    sh = int'(b % longint'(w));
    v = 1'b0; c = 1'b0; s = 0;
    case (op)
      4'd0: begin s = a + b; c = s[w]; v = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]); end
      4'd1: begin s = a + (~b & mask) + 1; c = s[w]; v = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = a ^ b;
      4'd5: s = (sa < sb) ? 1 : 0;
      4'd6: s = (a < b) ? 1 : 0;
      4'd7: s = a << sh;
      4'd8: s = a >> sh;
      4'd9: s = longint'(sa >>> sh);
      4'd10: s = a * b;
      4'd11: s = (a * b) >> w;
      4'd12: s = (b == 0) ? mask : a / b;
      4'd13: s = (b == 0) ? a : a % b;
      default: s = 0;
    endcase
    s = s & mask;
    e.res   = s[31:0];
    e.flags = {v, c, (s == 0), s[w-1]};
    e.lat   = (op >= 4'd10 && op <= 4'd13) ? w + 1 : 1;
    return e;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      if8.in_valid = v; if8.op = op; if8.A = a[7:0]; if8.B = b[7:0];
    end else begin
      if32.in_valid = v; if32.op = op; if32.A = a; if32.B = b;
    end
  endtask

  task automatic sample(input bit w8, output logic [31:0] r, output logic [3:0] f,
                        output logic ir, output logic ov);
    if (w8) begin
      r = {24'd0, if8.Result}; f = {if8.V, if8.C, if8.Z, if8.N};
      ir = if8.in_ready; ov = if8.out_valid;
    end else begin
      r = if32.Result; f = {if32.V, if32.C, if32.Z, if32.N};
      ir = if32.in_ready; ov = if32.out_valid;
    end
  endtask

  // Issue one op from IDLE (called at a negedge), wait for its result, compare, retire.
  task automatic do_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    exp_t e;
    int cyc;
    bit busy_ok;
    logic [31:0] r;
    logic [3:0] f;
    logic ir, ov;
    exp_q.push_back(model(w8 ? 8 : 32, op, a, b));
    drive(w8, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w8, 1'b0, 4'($urandom), $urandom, $urandom);
    cyc = 1;
    busy_ok = 1'b1;
    sample(w8, r, f, ir, ov);
    while (!ov && cyc < 200) begin
      if (ir !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
      sample(w8, r, f, ir, ov);
    end
    if (!ov) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL %s timeout: out_valid not seen within %0d cycles", name, cyc);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (r !== e.res) begin
      tests_failed++;
      $display("[TB] FAIL %s result: got 0x%08h expected 0x%08h", name, r, e.res);
    end
    tests_run++;
    if (f !== e.flags) begin
      tests_failed++;
      $display("[TB] FAIL %s flags VCZN: got %b expected %b", name, f, e.flags);
    end
    tests_run++;
    if (cyc !== e.lat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
    end
    if (e.lat > 1) begin
      tests_run++;
      if (!busy_ok) begin
        tests_failed++;
        $display("[TB] FAIL %s in_ready while busy: got 1 expected 0", name);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [3:0] f;
    logic ir, ov;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    if32.out_ready = 1'b1;
    if8.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(k == 1, r, f, ir, ov);
      tests_run++;
      if ({ir, ov, r, f} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
        tests_failed++;
        $display("[TB] FAIL reset_state xlen%0d: in_ready=%b out_valid=%b Result=0x%08h VCZN=%b expected 1 0 0x0 0000",
                 k == 1 ? 8 : 32, ir, ov, r, f);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_ops();
    do_op(1'b0, 4'd0, 32'h7FFF_FFFF, 32'h1, "add_overflow");
    do_op(1'b0, 4'd1, 32'd5, 32'd5, "sub_zero");
    do_op(1'b0, 4'd1, 32'd3, 32'd7, "sub_borrow");
    do_op(1'b0, 4'd1, 32'h8000_0000, 32'h1, "sub_overflow");
    do_op(1'b0, 4'd5, 32'hFFFF_FFFF, 32'h1, "slt_signed");
    do_op(1'b0, 4'd6, 32'hFFFF_FFFF, 32'h1, "sltu");
    do_op(1'b0, 4'd9, 32'h8000_0000, 32'h21, "sra_shamt_mask");
    do_op(1'b0, 4'd7, 32'h0000_00F1, 32'h24, "sll");
    do_op(1'b0, 4'd8, 32'h8000_00F0, 32'h3F, "srl");
    do_op(1'b0, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    do_op(1'b0, 4'd3, 32'hF000_0000, 32'h0000_000F, "or");
    do_op(1'b0, 4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, "xor_zero");
    do_op(1'b0, 4'd14, 32'h1234_5678, 32'h9, "op14");
    do_op(1'b0, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "op15");
  endtask

  task automatic test_muldiv();
    do_op(1'b0, 4'd10, 32'hFFFF_FFFF, 32'd2, "mul");
    do_op(1'b0, 4'd11, 32'hFFFF_FFFF, 32'd2, "mulhu");
    do_op(1'b0, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(1'b0, 4'd12, 32'd100, 32'd7, "divu");
    do_op(1'b0, 4'd13, 32'd100, 32'd7, "remu");
    do_op(1'b0, 4'd12, 32'h1234, 32'd0, "divu_by_zero");
    do_op(1'b0, 4'd13, 32'h1234, 32'd0, "remu_by_zero");
    do_op(1'b0, 4'd12, 32'hFFFF_FFFF, 32'h8000_0001, "divu_large");
    do_op(1'b0, 4'd13, 32'hFFFF_FFFF, 32'h8000_0001, "remu_large");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++)
      do_op(i[0], 4'($urandom_range(0, 15)), $urandom, $urandom, "random");
  endtask

  task automatic test_xlen8();
    do_op(1'b1, 4'd0, 32'h7F, 32'h01, "x8_add_overflow");
    do_op(1'b1, 4'd10, 32'hFF, 32'h02, "x8_mul");
    do_op(1'b1, 4'd11, 32'hFF, 32'h02, "x8_mulhu");
    do_op(1'b1, 4'd12, 32'hC8, 32'h07, "x8_divu");
  endtask

  task automatic test_backpressure();
    exp_t e1, e2;
    bit stable;
    logic [31:0] r;
    logic [3:0] f;
    logic ir, ov;
    exp_q.push_back(model(32, 4'd0, 32'hFFFF_FFF0, 32'h20));
    exp_q.push_back(model(32, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0));
    if32.out_ready = 1'b0;
    drive(1'b0, 1'b1, 4'd0, 32'hFFFF_FFF0, 32'h20);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    e1 = exp_q.pop_front();
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      sample(1'b0, r, f, ir, ov);
      if (r !== e1.res || f !== e1.flags || ir !== 1'b0 || ov !== 1'b1) begin
        stable = 1'b0;
        $display("[TB] FAIL backpressure_hold cycle %0d: Result=0x%08h VCZN=%b in_ready=%b out_valid=%b expected 0x%08h %b 0 1",
                 k, r, f, ir, ov, e1.res, e1.flags);
      end
    end
    tests_run++;
    if (!stable) tests_failed++;
    if32.out_ready = 1'b1;
    @(negedge clk);
    sample(1'b0, r, f, ir, ov);
    tests_run++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retire_cycle: in_ready=%b out_valid=%b expected 1 0", ir, ov);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    sample(1'b0, r, f, ir, ov);
    e2 = exp_q.pop_front();
    tests_run++;
    if (ov !== 1'b1 || r !== e2.res || f !== e2.flags) begin
      tests_failed++;
      $display("[TB] FAIL held_op_accept: out_valid=%b Result=0x%08h VCZN=%b expected 1 0x%08h %b",
               ov, r, f, e2.res, e2.flags);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit quiet;
    logic [31:0] r;
    logic [3:0] f;
    logic ir, ov;
    do_op(1'b0, 4'd12, 32'd100, 32'd7, "divu_before_reset");
    drive(1'b0, 1'b1, 4'd12, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sample(1'b0, r, f, ir, ov);
    tests_run++;
    if ({ir, ov, r, f} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_op: in_ready=%b out_valid=%b Result=0x%08h VCZN=%b expected 1 0 0x0 0000",
               ir, ov, r, f);
    end
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sample(1'b0, r, f, ir, ov);
      if (ov !== 1'b0 || ir !== 1'b1) quiet = 1'b0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("[TB] FAIL aborted_op_output: out_valid/in_ready changed after reset, expected 0/1");
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_muldiv();
    test_xlen8();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
